mc_mainfsm: RTL and testbench
=============================

// Module: mc_mainfsm
// PURPOSE
//  Main control FSM sequencing the multicycle ARM datapath (ALU, load/store, branch, MUL/UMULL, FPU).
//  Sits in the controller beside the decoder/condlogic. Drives datapath mux selects and raw write strobes.
//  condlogic gates RegW/MemW/NextPC/Branch into RegWrite/MemWrite/PCWrite.
//  Adds a memory-ready handshake and a counted multi-cycle FPU execute phase.
// PARAMETERS
//  FPU_LAT  2  cycles spent in FPUEX before FPUWB; legal range 1..15
// PORTS
//  clk        in   1  clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  Op         in   2  Instr[27:26]
//  Funct      in   6  Instr[25:20]; [5]=I, [0]=L (mem) / S, [3]=long (MUL)
//  MulFlag    in   1  Instr[7:4]==4'b1001 (multiply encoding)
//  MemReady   in   1  memory completes the current access this cycle
//  IRWrite    out  1  load instruction register
//  AdrSrc     out  1  0=PC, 1=Result
//  ALUSrcA    out  2  00=A, 01=PC
//  ALUSrcB    out  2  00=WriteData, 01=ExtImm, 10=4
//  ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
//  NextPC     out  1  PC update request
//  RegW       out  1  raw register write request
//  MemW       out  1  raw memory write request
//  Branch     out  1  branch request
//  ALUOp      out  1  1=decoder derives ALUControl from Funct, 0=add
//  RegSrc64b  out  1  multiply register-address remap
//  Src_64b    out  1  64-bit (long multiply) writeback select
//  FPUWrite   out  1  FPU register-file write enable
//  State      out  4  current state encoding, for debug/trace
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECR=6 EXECI=7 ALUWB=8
//   BRANCH=9 MULEX=10 MULWB=11 FPUEX=12 FPUWB=13. Codes 14/15 illegal -> FETCH next edge, all outputs 0.
//  Reset: reset high at a rising edge -> State=FETCH, cnt=0.
//   RegW/MemW/NextPC/IRWrite/FPUWrite/Branch are forced 0 while reset is high, whatever the state.
//  Outputs decode combinationally from State (Moore). Exceptions: in FETCH, IRWrite=NextPC=MemReady;
//   in MEMWR, MemW=1 for every cycle held. Unlisted outputs are 0.
//  FETCH:  AdrSrc=0 ALUSrcA=01 ALUSrcB=10 ResultSrc=10. Stay until MemReady, then DECODE.
//  DECODE: ALUSrcA=01 ALUSrcB=10 ResultSrc=10. Next state:
//   Op=00 & MulFlag & !Funct[5] -> MULEX; else Op=00 -> Funct[5] ? EXECI : EXECR
//   Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FPUEX (cnt cleared to 0)
//  MEMADR: ALUSrcB=01. Funct[0] ? MEMRD : MEMWR.
//  MEMRD:  AdrSrc=1. Hold until MemReady -> MEMWB.
//  MEMWB:  ResultSrc=01 RegW=1 -> FETCH.
//  MEMWR:  AdrSrc=1 MemW=1. Hold until MemReady -> FETCH.
//  EXECR:  ALUSrcB=00 ALUOp=1 -> ALUWB.
//  EXECI:  ALUSrcB=01 ALUOp=1 -> ALUWB.
//  ALUWB:  RegW=1 ResultSrc=00 -> FETCH.
//  BRANCH: ALUSrcB=01 ResultSrc=10 Branch=1 -> FETCH.
//  MULEX:  RegSrc64b=1 ALUOp=1 Src_64b=Funct[3] -> MULWB.
//  MULWB:  RegSrc64b=1 Src_64b=Funct[3] RegW=1 ResultSrc=00 -> FETCH.
//  FPUEX:  cnt increments each cycle; at cnt==FPU_LAT-1 -> FPUWB, cnt<=0.
//   Residency in FPUEX is exactly FPU_LAT cycles. cnt is 4 bits and never wraps.
//  FPUWB:  FPUWrite=1 -> FETCH.
//  Cycle counts with MemReady=1: ALU 4, LDR 5, STR 4, B 3, MUL 4, FPU 3+FPU_LAT.
//  MemReady is ignored outside FETCH/MEMRD/MEMWR.
//  Reset mid-instruction (e.g. in MEMWR or FPUEX) aborts: FETCH next edge, no strobe during reset.
// TESTING
//  Reset 1 cycle then MemReady=1, Op=00 Funct=000000 -> State 0,1,6,8,0; RegW=1 only in state 8.
//  LDR Op=01 Funct[0]=1, MemReady low 3 cycles in MEMRD -> State=3 held 3 cycles; MEMWB ResultSrc=01 RegW=1.
//  STR Op=01 Funct[0]=0, MemReady=0 2 cycles -> MemW=1 for 3 cycles in state 5, then FETCH.
//  UMULL Op=00 MulFlag=1 Funct=001000 -> states 10,11; RegSrc64b=1 and Src_64b=1 in both.
//  FPU Op=11, FPU_LAT=3 -> state 12 for 3 cycles, then 13 with FPUWrite=1, then 0.
//  FETCH with MemReady=0 5 cycles -> IRWrite=NextPC=0 throughout; reset asserted in FPUEX -> State=0, FPUWrite never 1.

Source files
------------

// File: rtl/mc_mainfsm_if.sv
// mc_mainfsm_if: decoder-side inputs and datapath control outputs of the main control FSM.
interface mc_mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MulFlag;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       RegSrc64b;
  logic       Src_64b;
  logic       FPUWrite;
  logic [3:0] State;
  modport master (
    output Op, Funct, MulFlag, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
           Branch, ALUOp, RegSrc64b, Src_64b, FPUWrite, State
  );
  modport slave (
    input  Op, Funct, MulFlag, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
           Branch, ALUOp, RegSrc64b, Src_64b, FPUWrite, State
  );
endinterface

// File: rtl/mc_mainfsm.sv
// mc_mainfsm: multicycle ARM main control FSM with memory-ready handshake and counted FPU execute.
module mc_mainfsm #(
  parameter int FPU_LAT = 2
) (
  input logic         clk,
  input logic         reset,
  mc_mainfsm_if.slave bus
);
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] MULEX  = 4'd10;
  localparam logic [3:0] MULWB  = 4'd11;
  localparam logic [3:0] FPUEX  = 4'd12;
  localparam logic [3:0] FPUWB  = 4'd13;
  localparam logic [3:0] LAST   = 4'(FPU_LAT - 1);
  logic [3:0] r_state, w_next;
  logic [3:0] r_cnt, w_cnt;
  logic       w_irw, w_adr, w_npc, w_regw, w_memw, w_br, w_aluop, w_rs64, w_s64, w_fpuw;
  logic [1:0] w_srca, w_srcb, w_res;
  logic       w_unused;
  assign w_unused = ^{bus.Funct[4], bus.Funct[2:1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
  end
  always_comb begin
    w_next = FETCH;
    w_cnt  = r_cnt;
    case (r_state)
      FETCH:  w_next = bus.MemReady ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          2'b00:   w_next = (bus.MulFlag && !bus.Funct[5]) ? MULEX : (bus.Funct[5] ? EXECI : EXECR);
          2'b01:   w_next = MEMADR;
          2'b10:   w_next = BRANCH;
          default: w_next = FPUEX;
        endcase
        w_cnt = (bus.Op == 2'b11) ? 4'd0 : r_cnt;
      end
      MEMADR: w_next = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  w_next = bus.MemReady ? MEMWB : MEMRD;
      MEMWR:  w_next = bus.MemReady ? FETCH : MEMWR;
      EXECR:  w_next = ALUWB;
      EXECI:  w_next = ALUWB;
      MULEX:  w_next = MULWB;
      // FPUEX residency is FPU_LAT cycles: count 0..LAST, then leave with the counter cleared
      FPUEX: begin
        w_next = (r_cnt == LAST) ? FPUWB : FPUEX;
        w_cnt  = (r_cnt == LAST) ? 4'd0 : r_cnt + 4'd1;
      end
      default: w_next = FETCH;
    endcase
  end
  always_comb begin
    w_irw   = 1'b0;
    w_adr   = 1'b0;
    w_srca  = 2'b00;
    w_srcb  = 2'b00;
    w_res   = 2'b00;
    w_npc   = 1'b0;
    w_regw  = 1'b0;
    w_memw  = 1'b0;
    w_br    = 1'b0;
    w_aluop = 1'b0;
    w_rs64  = 1'b0;
    w_s64   = 1'b0;
    w_fpuw  = 1'b0;
    case (r_state)
      FETCH: begin
        w_irw  = bus.MemReady;
        w_npc  = bus.MemReady;
        w_srca = 2'b01;
        w_srcb = 2'b10;
        w_res  = 2'b10;
      end
      DECODE: begin
        w_srca = 2'b01;
        w_srcb = 2'b10;
        w_res  = 2'b10;
      end
      MEMADR: w_srcb = 2'b01;
      MEMRD:  w_adr = 1'b1;
      MEMWB: begin
        w_res  = 2'b01;
        w_regw = 1'b1;
      end
      MEMWR: begin
        w_adr  = 1'b1;
        w_memw = 1'b1;
      end
      EXECR: w_aluop = 1'b1;
      EXECI: begin
        w_srcb  = 2'b01;
        w_aluop = 1'b1;
      end
      ALUWB: w_regw = 1'b1;
      BRANCH: begin
        w_srcb = 2'b01;
        w_res  = 2'b10;
        w_br   = 1'b1;
      end
      MULEX: begin
        w_rs64  = 1'b1;
        w_aluop = 1'b1;
        w_s64   = bus.Funct[3];
      end
      MULWB: begin
        w_rs64 = 1'b1;
        w_s64  = bus.Funct[3];
        w_regw = 1'b1;
      end
      FPUWB: w_fpuw = 1'b1;
      default: ;
    endcase
  end
  // write/fetch strobes are suppressed for the whole reset cycle so an aborted instruction commits nothing
  assign bus.IRWrite   = w_irw & ~reset;
  assign bus.NextPC    = w_npc & ~reset;
  assign bus.RegW      = w_regw & ~reset;
  assign bus.MemW      = w_memw & ~reset;
  assign bus.Branch    = w_br & ~reset;
  assign bus.FPUWrite  = w_fpuw & ~reset;
  assign bus.AdrSrc    = w_adr;
  assign bus.ALUSrcA   = w_srca;
  assign bus.ALUSrcB   = w_srcb;
  assign bus.ResultSrc = w_res;
  assign bus.ALUOp     = w_aluop;
  assign bus.RegSrc64b = w_rs64;
  assign bus.Src_64b   = w_s64;
  assign bus.State     = r_state;
endmodule

// File: tb/tb_mc_mainfsm.sv
// tb_mc_mainfsm: instruction-level trace model feeding a scoreboard checked every cycle.
module tb_mc_mainfsm;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset;
  mc_mainfsm_if bus ();
  mc_mainfsm #(.FPU_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [19:0] sbq[$];
  logic [3:0]  tq_s[$];
  logic        tq_m[$];
  int n_cmp = 0;
  int n_err = 0;
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic mr, input logic f3, input logic rst);
    logic irw, adr, npc, rw, mw, br, aop, r64, s64, fw;
    logic [1:0] sa, sb, rs;
    {irw, adr, npc, rw, mw, br, aop, r64, s64, fw} = '0;
    {sa, sb, rs} = '0;
    case (st)
      4'd0:  begin irw = mr; npc = mr; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd2:  sb = 2'b01;
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; end
      4'd6:  aop = 1'b1;
      4'd7:  begin sb = 2'b01; aop = 1'b1; end
      4'd8:  rw = 1'b1;
      4'd9:  begin sb = 2'b01; rs = 2'b10; br = 1'b1; end
      4'd10: begin r64 = 1'b1; aop = 1'b1; s64 = f3; end
      4'd11: begin r64 = 1'b1; s64 = f3; rw = 1'b1; end
      4'd13: fw = 1'b1;
      default: ;
    endcase
    if (rst) {irw, npc, rw, mw, br, fw} = '0;
    return {st, irw, adr, sa, sb, rs, npc, rw, mw, br, aop, r64, s64, fw};
  endfunction
  task automatic add(input logic [3:0] s, input logic m);
    tq_s.push_back(s);
    tq_m.push_back(m);
  endtask
  task automatic step(input logic [3:0] st, input logic mr, input logic rst);
    bus.MemReady = mr;
    reset = rst;
    sbq.push_back(exp_vec(st, mr, bus.Funct[3], rst));
    @(posedge clk);
    #1;
  endtask
  // kind: 0 ALU reg, 1 ALU imm, 2 LDR, 3 STR, 4 B, 5 MUL, 6 FPU
  task automatic run_instr(input int kind, input logic [5:0] f, input logic mf, input int fw, input int mw, input int abort);
    tq_s.delete();
    tq_m.delete();
    bus.Op = (kind == 2 || kind == 3) ? 2'b01 : (kind == 4) ? 2'b10 : (kind == 6) ? 2'b11 : 2'b00;
    bus.Funct = f;
    bus.MulFlag = mf;
    repeat (fw) add(4'd0, 1'b0);
    add(4'd0, 1'b1);
    add(4'd1, 1'($urandom_range(0, 1)));
    case (kind)
      0: begin add(4'd6, 1'($urandom_range(0, 1))); add(4'd8, 1'($urandom_range(0, 1))); end
      1: begin add(4'd7, 1'($urandom_range(0, 1))); add(4'd8, 1'($urandom_range(0, 1))); end
      2: begin
        add(4'd2, 1'($urandom_range(0, 1)));
        repeat (mw) add(4'd3, 1'b0);
        add(4'd3, 1'b1);
        add(4'd4, 1'($urandom_range(0, 1)));
      end
      3: begin
        add(4'd2, 1'($urandom_range(0, 1)));
        repeat (mw) add(4'd5, 1'b0);
        add(4'd5, 1'b1);
      end
      4: add(4'd9, 1'($urandom_range(0, 1)));
      5: begin add(4'd10, 1'($urandom_range(0, 1))); add(4'd11, 1'($urandom_range(0, 1))); end
      default: begin
        repeat (LAT) add(4'd12, 1'($urandom_range(0, 1)));
        add(4'd13, 1'($urandom_range(0, 1)));
      end
    endcase
    for (int i = 0; i < tq_s.size(); i++) begin
      step(tq_s[i], tq_m[i], i == abort);
      if (i == abort) break;
    end
    reset = 1'b0;
  endtask
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      logic [19:0] e, g;
      e = sbq.pop_front();
      g = {bus.State, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.NextPC,
           bus.RegW, bus.MemW, bus.Branch, bus.ALUOp, bus.RegSrc64b, bus.Src_64b, bus.FPUWrite};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL cycle check #%0d (state %0d): got %h want %h", n_cmp, e[19:16], g, e);
      end
    end
  end
  initial begin
    int kind, fw, mw, ab;
    logic [5:0] f;
    logic mf;
    reset = 1'b1;
    bus.MemReady = 1'b0;
    bus.Op = 2'b00;
    bus.Funct = 6'b0;
    bus.MulFlag = 1'b0;
    @(posedge clk);
    #1;
    step(4'd0, 1'b1, 1'b1);
    run_instr(0, 6'b000000, 1'b0, 0, 0, -1);
    run_instr(2, 6'b000001, 1'b0, 0, 3, -1);
    run_instr(3, 6'b000000, 1'b0, 0, 2, -1);
    run_instr(5, 6'b001000, 1'b1, 0, 0, -1);
    run_instr(5, 6'b000000, 1'b1, 0, 0, -1);
    run_instr(1, 6'b100000, 1'b1, 0, 0, -1);
    run_instr(4, 6'b000000, 1'b0, 0, 0, -1);
    run_instr(6, 6'b000000, 1'b0, 0, 0, -1);
    run_instr(0, 6'b000000, 1'b0, 5, 0, -1);
    run_instr(6, 6'b000000, 1'b0, 0, 0, 3);
    run_instr(3, 6'b000000, 1'b0, 0, 2, 3);
    run_instr(6, 6'b000000, 1'b0, 0, 0, -1);
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 6);
      f = 6'($urandom);
      mf = 1'($urandom);
      case (kind)
        0: begin f[5] = 1'b0; mf = 1'b0; end
        1: f[5] = 1'b1;
        2: f[0] = 1'b1;
        3: f[0] = 1'b0;
        5: begin f[5] = 1'b0; mf = 1'b1; end
        default: ;
      endcase
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : -1;
      run_instr(kind, f, mf, fw, mw, ab);
    end
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
